audio_energy_multi: RTL and testbench

Multi-channel successor of the mic amplitude block. Accepts frames of CHANNELS signed samples on each `ready` strobe from the AC97 path and accumulates per-channel short-term energy (|x|² >> PRE_SHIFT) over a fixed WINDOW of frames. At window close it applies shift, gain, saturation and a noise threshold, then publishes per-channel amplitudes plus the loudest-channel index for the tracking logic. Windows run back-to-back with no dropped frames.

---
 rtl/audio_energy_multi.sv | 110 +++++++++++
 tb/tb_audio_energy_multi.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/audio_energy_multi.sv
// audio_energy_multi: windowed per-channel energy with shift/gain/saturation, noise gate and loudest-channel index
module audio_energy_multi #(
    parameter int CHANNELS  = 2,
    parameter int DATA_W    = 8,
    parameter int WINDOW    = 800,
    parameter int PRE_SHIFT = 6,
    parameter int ACC_W     = 18,
    parameter int OUT_SHIFT = 2,
    parameter int OUT_W     = 16,
    parameter int GAIN      = 1,
    parameter int THRESHOLD = 6500,
    localparam int LW = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
    localparam int FW = $clog2(WINDOW + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ready,
    input  logic [CHANNELS*DATA_W-1:0]   audio_in,
    input  logic                         clear,
    output logic [CHANNELS*OUT_W-1:0]    amplitude,
    output logic [LW-1:0]                loudest,
    output logic [CHANNELS-1:0]          saturated,
    output logic                         done,
    output logic [FW-1:0]                frame_count
);
    localparam int SQ = 2 * (DATA_W + 1);
    localparam int SW = (ACC_W > SQ ? ACC_W : SQ) + 1;
    localparam int PW = (ACC_W > OUT_W ? ACC_W : OUT_W) + 32;
    localparam logic [ACC_W-1:0] AMAX = '1;
    localparam logic [OUT_W-1:0] OMAX = '1;

    logic [DATA_W:0]      mag      [CHANNELS];
    logic [SW-1:0]        sum      [CHANNELS];
    logic [ACC_W-1:0]     acc      [CHANNELS];
    logic [ACC_W-1:0]     next_acc [CHANNELS];
    logic [ACC_W-1:0]     snap     [CHANNELS];
    logic [PW-1:0]        sp       [CHANNELS];
    logic [PW-1:0]        s        [CHANNELS];
    logic [PW-1:0]        prod     [CHANNELS];
    logic [OUT_W-1:0]     g        [CHANNELS];
    logic [OUT_W-1:0]     best;
    logic [CHANNELS-1:0]  acc_sat, next_sat, snap_sat, red_sat;
    logic [CHANNELS*OUT_W-1:0] gated;
    logic [LW-1:0]        max_idx;
    logic                 snap_valid, close;

    assign close = ready && !clear && frame_count == FW'(WINDOW - 1);

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            mag[k] = audio_in[k*DATA_W+DATA_W-1] ? -{1'b1, audio_in[k*DATA_W +: DATA_W]}
                                                 : {1'b0, audio_in[k*DATA_W +: DATA_W]};
            sum[k] = SW'(acc[k]) + ((SW'(mag[k]) * SW'(mag[k])) >> PRE_SHIFT);
            next_sat[k] = acc_sat[k] | (sum[k] > SW'(AMAX));
            next_acc[k] = sum[k] > SW'(AMAX) ? AMAX : sum[k][ACC_W-1:0];
        end
    end

    // REDUCE: shift, clip, gain, clip, gate; loudest uses pre-gate values, ties to lowest index
    always_comb begin
        best = '0;
        max_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sp[k] = PW'(snap[k] >> OUT_SHIFT);
            s[k] = sp[k] > PW'(OMAX) ? PW'(OMAX) : sp[k];
            prod[k] = s[k] * PW'(GAIN);
            g[k] = prod[k] > PW'(OMAX) ? OMAX : prod[k][OUT_W-1:0];
            red_sat[k] = snap_sat[k] | (sp[k] > PW'(OMAX)) | (prod[k] > PW'(OMAX));
            gated[k*OUT_W +: OUT_W] = PW'(g[k]) > PW'(THRESHOLD) ? g[k] : '0;
            max_idx = (k == 0 || g[k] > best) ? LW'(k) : max_idx;
            best = (k == 0 || g[k] > best) ? g[k] : best;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc         <= '{default: '0};
            snap        <= '{default: '0};
            acc_sat     <= '0;
            snap_sat    <= '0;
            snap_valid  <= 1'b0;
            frame_count <= '0;
            amplitude   <= '0;
            loudest     <= '0;
            saturated   <= '0;
            done        <= 1'b0;
        end else begin
            snap_valid <= close;
            done       <= snap_valid;
            if (snap_valid) begin
                amplitude <= gated;
                loudest   <= max_idx;
                saturated <= red_sat;
            end
            if (close) begin
                snap     <= next_acc;
                snap_sat <= next_sat;
            end
            if (clear || close) begin
                acc         <= '{default: '0};
                acc_sat     <= '0;
                frame_count <= '0;
            end else if (ready) begin
                acc         <= next_acc;
                acc_sat     <= next_sat;
                frame_count <= frame_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_energy_multi.sv
// tb_audio_energy_multi: scoreboard bench over four instances differing in ACC_W/GAIN
module tb_audio_energy_multi;
    localparam int AW [4] = '{18, 10, 18, 18};
    localparam int GN [4] = '{1, 1, 300, 1100};

    typedef struct {
        int          d;
        int          t;
        logic [31:0] amp;
        logic        lo;
        logic [1:0]  sat;
    } exp_t;

    logic        clk, reset, clr;
    logic [3:0]  rdy;
    logic [15:0] audio;
    logic [31:0] amp [4];
    logic        lo  [4];
    logic [1:0]  sat [4];
    logic        dn  [4];
    logic [2:0]  fc  [4];
    exp_t        sb [$];
    exp_t        e;
    int          cyc, checks, errors;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        audio_energy_multi #(
            .CHANNELS(2), .DATA_W(8), .WINDOW(4), .PRE_SHIFT(6), .ACC_W(AW[i]),
            .OUT_SHIFT(2), .OUT_W(16), .GAIN(GN[i]), .THRESHOLD(10)
        ) dut (
            .clock(clk), .reset(reset), .ready(rdy[i]), .audio_in(audio), .clear(clr),
            .amplitude(amp[i]), .loudest(lo[i]), .saturated(sat[i]), .done(dn[i]),
            .frame_count(fc[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string n, input longint a, input longint b);
        checks++;
        if (a !== b) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, b, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (dn[d]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: dut %0d pulsed done with nothing expected (cycle %0d)", d, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_dut", d, e.d);
                    chk("done_cycle", cyc, e.t);
                    chk("amplitude", amp[d], e.amp);
                    chk("loudest", lo[d], e.lo);
                    chk("saturated", sat[d], e.sat);
                end
            end
        end
    end

    task automatic frame(input int d, input logic [7:0] a0, input logic [7:0] a1, input logic c);
        audio = {a1, a0};
        rdy = 4'b0001 << d;
        clr = c;
        @(posedge clk);
        #1;
        rdy = '0;
        clr = 1'b0;
    endtask

    task automatic win(input int d, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [31:0] ea, input logic el, input logic [1:0] es);
        for (int i = 0; i < 4; i++) begin
            chk("frame_count", fc[d], i);
            if (i == 3) sb.push_back('{d: d, t: cyc + 2, amp: ea, lo: el, sat: es});
            frame(d, a0, a1, 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        reset = 1'b1;
        rdy = '0;
        clr = 1'b0;
        audio = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_amplitude", amp[0], 0);
        chk("reset_loudest", lo[0], 0);
        chk("reset_saturated", sat[0], 0);
        chk("reset_done", dn[0], 0);
        chk("reset_frame_count", fc[0], 0);

        win(0, 8'h40, 8'hC0, 32'h0040_0040, 1'b0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        win(0, 8'h10, 8'h80, 32'h0100_0000, 1'b1, 2'b00);
        repeat (3) @(posedge clk);
        #1;

        win(1, 8'h80, 8'h00, 32'h0000_00FF, 1'b0, 2'b01);
        win(1, 8'h01, 8'h01, 32'h0000_0000, 1'b0, 2'b00);
        repeat (3) @(posedge clk);
        #1;

        for (int w = 0; w < 3; w++) win(0, 8'h40, 8'hC0, 32'h0040_0040, 1'b0, 2'b00);
        repeat (3) @(posedge clk);
        #1;

        frame(0, 8'h40, 8'hC0, 1'b0);
        frame(0, 8'h40, 8'hC0, 1'b0);
        chk("pre_clear_frame_count", fc[0], 2);
        frame(0, 8'h7F, 8'h7F, 1'b1);
        chk("clear_frame_count", fc[0], 0);
        chk("clear_keeps_amplitude", amp[0], 32'h0040_0040);
        win(0, 8'h10, 8'h80, 32'h0100_0000, 1'b1, 2'b00);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) frame(0, 8'h40, 8'hC0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_amplitude", amp[0], 0);
        chk("midreset_loudest", lo[0], 0);
        chk("midreset_saturated", sat[0], 0);
        chk("midreset_frame_count", fc[0], 0);
        chk("midreset_done", dn[0], 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        win(2, 8'h40, 8'h00, 32'h0000_4B00, 1'b0, 2'b00);
        win(3, 8'h40, 8'h00, 32'h0000_FFFF, 1'b0, 2'b01);
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
